// File: rtl/adder_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_arbiter : round-robin sharing of one registered adder among requesters
// rev 1.0
// ---------------------------------------------------------------------------
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH:0]           rsp_sum,
  output logic                     add_en,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH:0]           add_sum,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [GW-1:0]    pick;
  logic [GW-1:0]    idx;
  logic             pick_vld;

  // Search starts one past the previous winner and wraps, so the first hit is the RR choice.
  always_comb begin
    pick     = '0;
    idx      = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!pick_vld && req_valid[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          a_d     = req_a[int'(pick)*WIDTH +: WIDTH];
          b_d     = req_b[int'(pick)*WIDTH +: WIDTH];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        sum_d   = add_sum;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          last_grant_d = grant_q;
          op_count_d   = op_count_q + CNT_W'(1);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      op_count_q   <= op_count_d;
    end
  end

  // The accept strobe is masked during reset so a held request is never acknowledged then.
  assign req_ready = (state_q == IDLE && pick_vld && rst) ? (NUM_REQ'(1) << pick) : '0;
  assign rsp_valid = (state_q == RESP) ? (NUM_REQ'(1) << grant_q) : '0;
  assign rsp_sum   = sum_q;
  assign add_en    = (state_q == ISSUE);
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = op_count_q;

endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin controller that shares a single registered 8-bit adder (one-cycle latency, `sum` valid the cycle after `en`) among `NUM_REQ` requesters. Each requester presents operands with a valid/ready handshake. The arbiter grants one requester, drives the adder's `en`/`a`/`b`, captures `sum`, and returns the result to that requester with a response handshake. It sits between the client logic and the adder instance and is the only block allowed to drive the adder inputs.

## Interface
Parameters:
- `NUM_REQ`, default 4, number of requesters (2..8).
- `WIDTH`, default 8, operand width; must match the adder.
- `CNT_W`, default 16, width of the completed-operation counter.

Ports:
- `clk` in 1: single clock; everything is sampled on its rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `req_valid` in NUM_REQ: per-requester operand valid.
- `req_a` in NUM_REQ*WIDTH: packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b` in NUM_REQ*WIDTH: packed operand B, same packing as `req_a`.
- `req_ready` out NUM_REQ: one-hot accept strobe.
- `rsp_valid` out NUM_REQ: one-hot result valid, addressed to the granted requester.
- `rsp_ready` in NUM_REQ: per-requester result accept.
- `rsp_sum` out WIDTH+1: result, shared by all requesters.
- `add_en` out 1: adder enable.
- `add_a` out WIDTH: adder operand A.
- `add_b` out WIDTH: adder operand B.
- `add_sum` in WIDTH+1: adder result.
- `busy` out 1: high in every state except IDLE.
- `op_count` out CNT_W: number of completed operations.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, select grant g by round-robin: search from `last_grant+1` upward, modulo NUM_REQ.
  - Drive `req_ready[g]=1`. This is combinational from state and `req_valid`, and only one bit is ever high.
  - In the same cycle, latch `req_a[g]`, `req_b[g]` and g into internal registers, then go to ISSUE.
  - If no `req_valid` is high, stay in IDLE with all strobes 0.
- **ISSUE**
  - `add_en=1`; `add_a`/`add_b` are driven from the latched operands.
  - Go to WAIT unconditionally.
- **WAIT**
  - `add_en=0`; `add_a`/`add_b` hold their values.
  - Capture `add_sum` into the result register, then go to RESP.
- **RESP**
  - `rsp_valid[g]=1`; `rsp_sum` shows the result register.
  - Stay in RESP until `rsp_ready[g]=1`. When it is, set `last_grant<=g`, increment `op_count` (wraps modulo 2^CNT_W), and go to IDLE.
  - `rsp_ready` bits of non-granted requesters are ignored.
- Arithmetic: `rsp_sum` is exactly WIDTH+1 bits and carries the carry-out. The arbiter does not truncate or modify the sum.
- After its handshake, a requester may drop `req_valid` or change operands freely; the in-flight operation is unaffected.
- `req_valid` from other requesters during ISSUE/WAIT/RESP is not acknowledged. Those requesters wait; there is no queueing.
- Reset mid-operation: the in-flight operation is abandoned, no response is issued, and the FSM returns to IDLE.

## Timing
- Reset values:
  - Outputs: `req_ready=0`, `rsp_valid=0`, `rsp_sum=0`, `add_en=0`, `add_a=0`, `add_b=0`, `busy=0`, `op_count=0`.
  - Internal: `last_grant=NUM_REQ-1`, so requester 0 has first priority.
- Cycle T: handshake in IDLE.
- Cycle T+1: ISSUE; `add_en=1`.
- Cycle T+2: WAIT; `add_sum == add_a + add_b` as driven in T+1.
- Cycle T+3: earliest `rsp_valid`.
- With `rsp_ready` held high, the response handshake is at T+3, IDLE is re-entered at T+4, and the next grant can occur at T+4.
- Maximum throughput is one operation per 4 cycles.
- `add_en` is high for exactly one cycle per operation and never in IDLE, WAIT or RESP.
- Simultaneous requests are resolved by round-robin only. A continuously requesting client waits at most NUM_REQ-1 operations.
- `rsp_valid` and `rsp_sum` are stable from assertion until the handshake.

## Test plan
- **Reset:** hold `rst=0` for 3 cycles with all `req_valid=1` -> all outputs stay at 0 and there is no `req_ready`. Release `rst`: requester 0 is granted first.
- **Single operation:** requester 2 sends a=200, b=100 with `rsp_ready` held 1 -> `add_en` pulses in T+1; `rsp_valid[2]` in T+3 with `rsp_sum=300` (0x12C); `op_count=1`.
- **Round-robin:** all four `req_valid` held high with `rsp_ready=1` -> grants follow the order 0,1,2,3,0, one grant every 4 cycles. Operands a=i, b=10*i return i+10*i.
- **Backpressure:** requester 1 sends 255+255 with `rsp_ready[1]` held 0 for 5 cycles -> `rsp_valid[1]` stays 1 and `rsp_sum=510` stays stable. Requester 0 gets no `req_ready` until requester 1's response is accepted.
- **Reset mid-operation:** assert `rst=0` in the WAIT cycle -> no `rsp_valid` appears, `op_count` is unchanged (0), and the FSM is in IDLE after release.
- **Counter wrap:** with CNT_W=2, complete 5 operations -> `op_count` reads 1.
